// File: rtl/ex_issue.sv
// ex_issue: execute-issue stage ahead of the 32-bit ALU; selects operands, resolves RAW hazards, holds ALU inputs.
// Define EX_ISSUE_FWD_EN to forward from EX/WB; when undefined, hazards stall the input instead.
package ex_issue_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;
endpackage

module ex_issue
  import ex_issue_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  alu_op_t     in_op,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_rs1_val,
  input  logic [31:0] in_rs2_val,
  input  logic [31:0] in_imm,
  input  logic        in_use_pc,
  input  logic        in_use_imm,
  input  logic [4:0]  in_rd,
  input  logic [31:0] alu_result,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output alu_op_t     out_op,
  output logic [31:0] out_arg_1,
  output logic [31:0] out_arg_2,
  output logic [4:0]  out_rd
);

  logic        valid_q, valid_d;
  alu_op_t     op_q, op_d;
  logic [31:0] arg_1_q, arg_1_d;
  logic [31:0] arg_2_q, arg_2_d;
  logic [4:0]  rd_q, rd_d;

  logic        ex_hit_1_s, ex_hit_2_s, wb_hit_1_s, wb_hit_2_s;
  logic        hazard_stall_s, take_in_s;
  logic [31:0] src_1_s, src_2_s;

  // Source matches; x0 never matches and an operand replaced by pc/imm is ignored.
  always_comb begin
    ex_hit_1_s = !in_use_pc  && valid_q && (rd_q != 5'd0)  && (rd_q == in_rs1);
    ex_hit_2_s = !in_use_imm && valid_q && (rd_q != 5'd0)  && (rd_q == in_rs2);
    wb_hit_1_s = !in_use_pc  && wb_en   && (wb_rd != 5'd0) && (wb_rd == in_rs1);
    wb_hit_2_s = !in_use_imm && wb_en   && (wb_rd != 5'd0) && (wb_rd == in_rs2);
  end

`ifdef EX_ISSUE_FWD_EN
  // Forwarding: the instruction in the ALU is younger than the WB write, so EX wins.
  always_comb begin
    hazard_stall_s = 1'b0;
    if (ex_hit_1_s) begin
      src_1_s = alu_result;
    end else if (wb_hit_1_s) begin
      src_1_s = wb_data;
    end else begin
      src_1_s = in_rs1_val;
    end
    if (ex_hit_2_s) begin
      src_2_s = alu_result;
    end else if (wb_hit_2_s) begin
      src_2_s = wb_data;
    end else begin
      src_2_s = in_rs2_val;
    end
  end
`else
  logic unused_fwd_s;

  // No bypass: any pending write to a used source holds the instruction at the input.
  always_comb begin
    src_1_s        = in_rs1_val;
    src_2_s        = in_rs2_val;
    hazard_stall_s = ex_hit_1_s | ex_hit_2_s | wb_hit_1_s | wb_hit_2_s;
    unused_fwd_s   = ^{alu_result, wb_data};
  end
`endif

  // Handshake and holding-register next state.
  always_comb begin
    in_ready  = !flush && (!valid_q || out_ready) && !hazard_stall_s;
    take_in_s = in_valid && in_ready;
    valid_d   = valid_q;
    op_d      = op_q;
    arg_1_d   = arg_1_q;
    arg_2_d   = arg_2_q;
    rd_d      = rd_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (take_in_s) begin
      valid_d = 1'b1;
      op_d    = in_op;
      arg_1_d = in_use_pc  ? in_pc  : src_1_s;
      arg_2_d = in_use_imm ? in_imm : src_2_s;
      rd_d    = in_rd;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Holding register driving the ALU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      op_q    <= ALU_ADD;
      arg_1_q <= 32'd0;
      arg_2_q <= 32'd0;
      rd_q    <= 5'd0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      arg_1_q <= arg_1_d;
      arg_2_q <= arg_2_d;
      rd_q    <= rd_d;
    end
  end

  assign out_valid = valid_q;
  assign out_op    = op_q;
  assign out_arg_1 = arg_1_q;
  assign out_arg_2 = arg_2_q;
  assign out_rd    = rd_q;

endmodule

// File: tb/tb_ex_issue.sv
// Scoreboard bench for ex_issue: directed test-plan cases, then randomized traffic against a reference model.
module tb_ex_issue;
  import ex_issue_pkg::*;

  logic        clk, rst_n, flush, in_valid, in_ready;
  alu_op_t     in_op, out_op;
  logic [31:0] in_pc, in_rs1_val, in_rs2_val, in_imm, alu_result, wb_data, out_arg_1, out_arg_2;
  logic [4:0]  in_rs1, in_rs2, in_rd, wb_rd, out_rd;
  logic        in_use_pc, in_use_imm, wb_en, out_valid, out_ready;

  ex_issue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
    .in_use_pc(in_use_pc), .in_use_imm(in_use_imm), .in_rd(in_rd),
    .alu_result(alu_result), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_arg_1(out_arg_1), .out_arg_2(out_arg_2), .out_rd(out_rd)
  );

  typedef struct packed {
    logic        in_valid, flush, out_ready;
    alu_op_t     op;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2;
    logic [31:0] rs1_val, rs2_val, imm;
    logic        use_pc, use_imm;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
  } stim_t;

  typedef struct packed {
    alu_op_t     op;
    logic [31:0] a1, a2;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic m_valid = 1'b0;
  logic [4:0] m_rd = 5'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference: the value an instruction reads for a used source register.
  function automatic logic [31:0] resolve(input logic used, input logic [4:0] rs,
                                          input logic [31:0] rf_val, input stim_t s,
                                          output logic hazard);
    logic pending_ex, pending_wb;
    pending_ex = used && rs != 5'd0 && m_valid && m_rd == rs;
    pending_wb = used && rs != 5'd0 && s.wb_en && s.wb_rd == rs;
`ifdef EX_ISSUE_FWD_EN
    hazard = 1'b0;
    if (pending_ex) return s.alu_result;
    if (pending_wb) return s.wb_data;
    return rf_val;
`else
    hazard = pending_ex || pending_wb;
    return rf_val;
`endif
  endfunction

  function automatic stim_t idle_stim();
    stim_t s;
    s = '0;
    s.op = ALU_ADD;
    s.out_ready = 1'b1;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.in_valid   = ($urandom_range(0, 9) < 8);
    s.flush      = ($urandom_range(0, 15) == 0);
    s.out_ready  = ($urandom_range(0, 3) != 0);
    s.op         = alu_op_t'(4'($urandom_range(0, 9)));
    s.pc         = $urandom;
    s.rs1        = 5'($urandom_range(0, 3));
    s.rs2        = 5'($urandom_range(0, 3));
    s.rs1_val    = $urandom;
    s.rs2_val    = $urandom;
    s.imm        = $urandom;
    s.use_pc     = ($urandom_range(0, 3) == 0);
    s.use_imm    = ($urandom_range(0, 4) < 2);
    s.rd         = 5'($urandom_range(0, 3));
    s.alu_result = $urandom;
    s.wb_en      = ($urandom_range(0, 1) == 1);
    s.wb_rd      = 5'($urandom_range(0, 3));
    s.wb_data    = $urandom;
    return s;
  endfunction

  // Applies one cycle of stimulus at posedge+1, checks handshake, returns at next posedge+1.
  task automatic do_cycle(input stim_t s, output logic got_ready);
    logic h1, h2, exp_ready;
    exp_t e;
    in_valid = s.in_valid; flush = s.flush; out_ready = s.out_ready; in_op = s.op;
    in_pc = s.pc; in_rs1 = s.rs1; in_rs2 = s.rs2; in_rs1_val = s.rs1_val; in_rs2_val = s.rs2_val;
    in_imm = s.imm; in_use_pc = s.use_pc; in_use_imm = s.use_imm; in_rd = s.rd;
    alu_result = s.alu_result; wb_en = s.wb_en; wb_rd = s.wb_rd; wb_data = s.wb_data;
    #1;
    e.op = s.op;
    e.rd = s.rd;
    e.a1 = resolve(!s.use_pc, s.rs1, s.rs1_val, s, h1);
    e.a2 = resolve(!s.use_imm, s.rs2, s.rs2_val, s, h2);
    if (s.use_pc)  e.a1 = s.pc;
    if (s.use_imm) e.a2 = s.imm;
    exp_ready = !s.flush && (!m_valid || s.out_ready) && !h1 && !h2;
    got_ready = in_ready;
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    if (s.in_valid && exp_ready) sb.push_back(e);
    if (s.flush) begin
      m_valid = 1'b0;
    end else if (s.in_valid && exp_ready) begin
      m_valid = 1'b1;
      m_rd    = s.rd;
    end else if (m_valid && s.out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: the held instruction must match the scoreboard head until it leaves or is flushed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: out_valid=1 with no expected entry at %0t", $time);
        end else begin
          e = sb[0];
          chk("out_op", {28'd0, out_op}, {28'd0, e.op});
          chk("out_arg_1", out_arg_1, e.a1);
          chk("out_arg_2", out_arg_2, e.a2);
          chk("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
          if (out_ready || flush) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    stim_t s;
    logic  r;
    rst_n = 1'b0;
    void'(idle_stim());
    s = idle_stim();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; in_op = ALU_SUB;
    in_pc = 32'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_rs1_val = 32'd0; in_rs2_val = 32'd0;
    in_imm = 32'd0; in_use_pc = 1'b0; in_use_imm = 1'b0; in_rd = 5'd0;
    alu_result = 32'd0; wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_op", {28'd0, out_op}, {28'd0, ALU_ADD});
    chk("rst_out_arg_1", out_arg_1, 32'd0);
    chk("rst_out_arg_2", out_arg_2, 32'd0);
    chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Basic issue: rs1 value 5, immediate 7, rd 3.
    s = idle_stim(); s.in_valid = 1'b1; s.rs1 = 5'd1; s.rs1_val = 32'd5;
    s.use_imm = 1'b1; s.imm = 32'd7; s.rd = 5'd3;
    do_cycle(s, r);
    chk("basic_valid", {31'd0, out_valid}, 32'd1);
    chk("basic_arg_1", out_arg_1, 32'd5);
    chk("basic_arg_2", out_arg_2, 32'd7);
    chk("basic_rd", {27'd0, out_rd}, 32'd3);

    // EX hazard on rs1 against held rd 3.
    s = idle_stim(); s.in_valid = 1'b1; s.rs1 = 5'd3; s.rs1_val = 32'd0;
    s.use_imm = 1'b1; s.imm = 32'd1; s.rd = 5'd6; s.alu_result = 32'd12;
    do_cycle(s, r);
`ifdef EX_ISSUE_FWD_EN
    chk("ex_fwd_arg_1", out_arg_1, 32'd12);
`else
    chk("ex_stall_ready", {31'd0, r}, 32'd0);
`endif

    // WB hazard on rs2.
    s = idle_stim(); s.in_valid = 1'b1; s.use_pc = 1'b1; s.pc = 32'h100; s.rs2 = 5'd4;
    s.rs2_val = 32'd1; s.wb_en = 1'b1; s.wb_rd = 5'd4; s.wb_data = 32'd99; s.rd = 5'd7;
    do_cycle(s, r);
`ifdef EX_ISSUE_FWD_EN
    chk("wb_fwd_arg_2", out_arg_2, 32'd99);
`else
    chk("wb_stall_ready", {31'd0, r}, 32'd0);
`endif

    // EX and WB both match rs2: EX value wins.
    s = idle_stim(); s.in_valid = 1'b1; s.rd = 5'd4; s.rs1_val = 32'd0; s.rs2_val = 32'd0;
    do_cycle(s, r);
    s = idle_stim(); s.in_valid = 1'b1; s.use_pc = 1'b1; s.rs2 = 5'd4; s.rs2_val = 32'd2;
    s.wb_en = 1'b1; s.wb_rd = 5'd4; s.wb_data = 32'd99; s.alu_result = 32'd55; s.rd = 5'd0;
    do_cycle(s, r);
`ifdef EX_ISSUE_FWD_EN
    chk("prio_arg_2", out_arg_2, 32'd55);
`else
    chk("prio_stall_ready", {31'd0, r}, 32'd0);
`endif

    // x0 never forwards, even with wb_rd 0 written.
    s = idle_stim(); s.in_valid = 1'b1; s.use_pc = 1'b1; s.rs2 = 5'd0; s.rs2_val = 32'h1234;
    s.wb_en = 1'b1; s.wb_rd = 5'd0; s.wb_data = 32'd99; s.alu_result = 32'd55; s.rd = 5'd10;
    do_cycle(s, r);
    chk("x0_ready", {31'd0, r}, 32'd1);
    chk("x0_arg_2", out_arg_2, 32'h1234);

    // Backpressure holds the output for three cycles, then releases.
    for (int i = 0; i < 3; i++) begin
      s = idle_stim(); s.in_valid = 1'b1; s.out_ready = 1'b0; s.rd = 5'd11;
      do_cycle(s, r);
      chk("bp_ready", {31'd0, r}, 32'd0);
      chk("bp_arg_2", out_arg_2, 32'h1234);
      chk("bp_rd", {27'd0, out_rd}, 32'd10);
    end
    s = idle_stim(); s.in_valid = 1'b1; s.rd = 5'd11;
    do_cycle(s, r);
    chk("bp_release_ready", {31'd0, r}, 32'd1);

    // Flush kills the held instruction and refuses the incoming one.
    s = idle_stim(); s.in_valid = 1'b1; s.flush = 1'b1; s.out_ready = 1'b0; s.rd = 5'd12;
    do_cycle(s, r);
    chk("flush_ready", {31'd0, r}, 32'd0);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset in the middle of a hold.
    s = idle_stim(); s.in_valid = 1'b1; s.rs1_val = 32'h55; s.rd = 5'd2;
    do_cycle(s, r);
    s = idle_stim(); s.out_ready = 1'b0;
    do_cycle(s, r);
    #5;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    sb.delete();
    m_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_arg_1", out_arg_1, 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 3000; i++) begin
      do_cycle(rand_stim(), r);
    end

    for (int i = 0; i < 20; i++) begin
      if (m_valid || sb.size() != 0) do_cycle(idle_stim(), r);
    end
    chk("drain_sb_size", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
